cache_data_array_p: RTL and testbench
=====================================

CACHE_DATA_ARRAY_P -- requirements
Module: cache_data_array_p

Interface
REQ-001 SHALL have parameter WORD_W, default 8, bits per word.
REQ-002 SHALL have parameter WORDS, default 8, words per cache line (power of 2, >=2).
REQ-003 SHALL have parameter LINES, default 64, lines per way (power of 2).
REQ-004 SHALL have parameter WAYS, default 2, associativity (power of 2, >=1; way port width = max(1,log2 WAYS)).
REQ-005 SHALL have ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- index  in  log2 LINES  line select
- way  in  way width  way select
- offset  in  log2 WORDS  word within line
- rd_en  in  1  processor read request
- wr_en  in  1  processor write request
- wdata  in  WORD_W  processor write data
- rdata  out  WORD_W  registered read data
- rvalid  out  1  rdata valid pulse
- fill_start  in  1  begin line fill at index/way
- fill_valid  in  1  fill beat valid
- fill_data  in  WORD_W  fill beat, word 0 first
- fill_done  out  1  one-cycle pulse, fill complete
- evict_start  in  1  begin line read-out at index/way
- evict_valid  out  1  evict beat valid
- evict_data  out  WORD_W  evict beat, word 0 first
- evict_last  out  1  final evict beat
- busy  out  1  FILL or EVICT in progress
REQ-006 SHALL use one clock; reset SHALL be asynchronous and active-low.

Function
REQ-007 SHALL store WAYS x LINES x WORDS words; storage not reset.
REQ-008 FSM states: IDLE, FILL, EVICT; busy=1 exactly when state != IDLE.
REQ-009 IDLE, rd_en=1, wr_en=0: rdata = word[way][index][offset] and rvalid=1 on the following cycle (latency 1); rvalid=0 otherwise.
REQ-010 IDLE, wr_en=1: word[way][index][offset] <= wdata at the edge; rd_en ignored that cycle (no rvalid).
REQ-011 rdata SHALL hold its last value when rvalid=0.
REQ-012 IDLE, evict_start=1: latch index/way, counter=0, go EVICT; rd_en/wr_en/fill_start ignored that cycle.
REQ-013 IDLE, fill_start=1, evict_start=0: latch index/way, counter=0, go FILL; rd_en/wr_en ignored that cycle.
REQ-014 FILL: each cycle with fill_valid=1 writes fill_data to word[counter] of the latched line, counter+1; fill_valid=0 stalls with no write.
REQ-015 FILL: beat with counter=WORDS-1 SHALL return state to IDLE and assert fill_done for the following cycle only.
REQ-016 EVICT: on each of WORDS consecutive cycles after entry, evict_valid=1, evict_data=word[counter] of the latched line, counter+1; no stall.
REQ-017 evict_last=1 only with the beat counter=WORDS-1; state returns to IDLE after that beat.
REQ-018 While busy: rd_en, wr_en, fill_start, evict_start ignored; rvalid=0.
REQ-019 evict_valid/evict_last/evict_data SHALL be registered outputs; evict_data=0 when evict_valid=0.
REQ-020 Counter width log2 WORDS; no wrap beyond WORDS-1 within a transfer.
REQ-021 An IDLE request on the cycle after fill_done or evict_last SHALL be accepted.

Reset
REQ-022 rst_n=0: state=IDLE, counter=0, rdata=0, rvalid=0, fill_done=0, evict_valid=0, evict_last=0, evict_data=0, busy=0, immediately (asynchronous).
REQ-023 Reset mid-FILL: fill aborted, no fill_done, words already written retained; mid-EVICT: beats stop, no evict_last.

Verification
REQ-024 Write 0xA5 way1/index5/offset3, read same next cycle -> rvalid=1 with rdata=0xA5 one cycle after rd_en; way0/index5/offset3 unaffected.
REQ-025 fill_start way0/index9, 8 beats 0x10..0x17 with fill_valid low on beats 3 and 6 -> fill_done once after 8th beat; reads of offsets 0..7 return 0x10..0x17.
REQ-026 evict_start on that line -> evict_valid 8 consecutive cycles, data 0x10..0x17, evict_last only with 0x17; busy then 0.
REQ-027 fill_start and evict_start same cycle -> EVICT entered, fill ignored; rd_en during busy -> no rvalid.
REQ-028 rst_n low after 4 fill beats -> all outputs 0 immediately, no fill_done; words 0..3 hold written values, new request accepted after release.
REQ-029 rd_en and wr_en same cycle -> write performed, rvalid=0 next cycle.

Source files
------------

// File: rtl/cache_data_array_p.sv
// Set-associative cache data array: single-word processor read/write port plus
// whole-line fill (refill) and evict (write-back) burst engines.
module cache_data_array_p #(
    parameter int WORD_W = 8,
    parameter int WORDS  = 8,
    parameter int LINES  = 64,
    parameter int WAYS   = 2,
    localparam int OFF_W = $clog2(WORDS),
    localparam int IDX_W = $clog2(LINES),
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [IDX_W-1:0]  index,
    input  logic [WAY_W-1:0]  way,
    input  logic [OFF_W-1:0]  offset,
    input  logic              rd_en,
    input  logic              wr_en,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata,
    output logic              rvalid,
    input  logic              fill_start,
    input  logic              fill_valid,
    input  logic [WORD_W-1:0] fill_data,
    output logic              fill_done,
    input  logic              evict_start,
    output logic              evict_valid,
    output logic [WORD_W-1:0] evict_data,
    output logic              evict_last,
    output logic              busy
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FILL  = 2'd1;
    localparam logic [1:0] S_EVICT = 2'd2;

    localparam int WAY_BITS = (WAYS > 1) ? $clog2(WAYS) : 0;
    localparam int ADDR_W   = WAY_BITS + IDX_W + OFF_W;
    localparam int DEPTH    = WAYS * LINES * WORDS;
    localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(WORDS - 1);

    logic [WORD_W-1:0] mem [DEPTH];

    logic [1:0]        state_q, state_d;
    logic [OFF_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  lat_index_q, lat_index_d;
    logic [WAY_W-1:0]  lat_way_q, lat_way_d;
    logic [WORD_W-1:0] rdata_q, rdata_d;
    logic              rvalid_q, rvalid_d;
    logic              fill_done_q, fill_done_d;
    logic              evict_valid_q, evict_valid_d;
    logic              evict_last_q, evict_last_d;
    logic [WORD_W-1:0] evict_data_q, evict_data_d;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr, mem_raddr, req_addr, line_addr;
    logic [WORD_W-1:0] mem_wdata, mem_rdata;

    // With a single way the 1-bit way field is dropped by the truncating cast.
    assign req_addr  = ADDR_W'({way, index, offset});
    assign line_addr = ADDR_W'({lat_way_q, lat_index_q, cnt_q});
    assign mem_raddr = (state_q == S_EVICT) ? line_addr : req_addr;
    assign mem_rdata = mem[mem_raddr];

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        lat_index_d   = lat_index_q;
        lat_way_d     = lat_way_q;
        rdata_d       = rdata_q;
        rvalid_d      = 1'b0;
        fill_done_d   = 1'b0;
        evict_valid_d = 1'b0;
        evict_last_d  = 1'b0;
        evict_data_d  = '0;
        mem_we        = 1'b0;
        mem_waddr     = req_addr;
        mem_wdata     = wdata;

        case (state_q)
            S_IDLE: begin
                if (evict_start) begin
                    state_d     = S_EVICT;
                    cnt_d       = '0;
                    lat_index_d = index;
                    lat_way_d   = way;
                end else if (fill_start) begin
                    state_d     = S_FILL;
                    cnt_d       = '0;
                    lat_index_d = index;
                    lat_way_d   = way;
                end else if (wr_en) begin
                    mem_we = 1'b1;
                end else if (rd_en) begin
                    rvalid_d = 1'b1;
                    rdata_d  = mem_rdata;
                end
            end
            S_FILL: begin
                mem_waddr = line_addr;
                mem_wdata = fill_data;
                if (fill_valid) begin
                    mem_we = 1'b1;
                    if (cnt_q == LAST_WORD) begin
                        state_d     = S_IDLE;
                        cnt_d       = '0;
                        fill_done_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + OFF_W'(1);
                    end
                end
            end
            S_EVICT: begin
                evict_valid_d = 1'b1;
                evict_data_d  = mem_rdata;
                if (cnt_q == LAST_WORD) begin
                    state_d      = S_IDLE;
                    cnt_d        = '0;
                    evict_last_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + OFF_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            lat_index_q   <= '0;
            lat_way_q     <= '0;
            rdata_q       <= '0;
            rvalid_q      <= 1'b0;
            fill_done_q   <= 1'b0;
            evict_valid_q <= 1'b0;
            evict_last_q  <= 1'b0;
            evict_data_q  <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            lat_index_q   <= lat_index_d;
            lat_way_q     <= lat_way_d;
            rdata_q       <= rdata_d;
            rvalid_q      <= rvalid_d;
            fill_done_q   <= fill_done_d;
            evict_valid_q <= evict_valid_d;
            evict_last_q  <= evict_last_d;
            evict_data_q  <= evict_data_d;
        end
    end

    // Storage is deliberately left out of reset so an aborted fill keeps its words.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign rdata       = rdata_q;
    assign rvalid      = rvalid_q;
    assign fill_done   = fill_done_q;
    assign evict_valid = evict_valid_q;
    assign evict_last  = evict_last_q;
    assign evict_data  = evict_data_q;
    assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_cache_data_array_p.sv
// Scenario bench for cache_data_array_p: reference array model plus queues of
// expected read and evict results, compared when the DUT presents them.
module tb_cache_data_array_p;

    localparam int WORD_W = 8;
    localparam int WORDS  = 8;
    localparam int LINES  = 64;
    localparam int WAYS   = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] index;
    logic [0:0] way;
    logic [2:0] offset;
    logic       rd_en, wr_en;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       rvalid;
    logic       fill_start, fill_valid;
    logic [7:0] fill_data;
    logic       fill_done;
    logic       evict_start;
    logic       evict_valid;
    logic [7:0] evict_data;
    logic       evict_last;
    logic       busy;

    cache_data_array_p #(.WORD_W(WORD_W), .WORDS(WORDS), .LINES(LINES), .WAYS(WAYS)) dut (
        .clk(clk), .rst_n(rst_n), .index(index), .way(way), .offset(offset),
        .rd_en(rd_en), .wr_en(wr_en), .wdata(wdata), .rdata(rdata), .rvalid(rvalid),
        .fill_start(fill_start), .fill_valid(fill_valid), .fill_data(fill_data),
        .fill_done(fill_done), .evict_start(evict_start), .evict_valid(evict_valid),
        .evict_data(evict_data), .evict_last(evict_last), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } ev_t;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] model [WAYS][LINES][WORDS];
    logic [7:0] rd_q [$];
    ev_t        ev_q [$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        index = '0; way = '0; offset = '0;
        rd_en = 1'b0; wr_en = 1'b0; wdata = '0;
        fill_start = 1'b0; fill_valid = 1'b0; fill_data = '0;
        evict_start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        step();
        step();
        n_checks++; if (rdata !== 8'h00) begin n_errors++; $display("FAIL reset_rdata: got %h want 00", rdata); end
        n_checks++; if (rvalid !== 1'b0) begin n_errors++; $display("FAIL reset_rvalid: got %b want 0", rvalid); end
        n_checks++; if (fill_done !== 1'b0) begin n_errors++; $display("FAIL reset_fill_done: got %b want 0", fill_done); end
        n_checks++; if (evict_valid !== 1'b0) begin n_errors++; $display("FAIL reset_evict_valid: got %b want 0", evict_valid); end
        n_checks++; if (evict_last !== 1'b0) begin n_errors++; $display("FAIL reset_evict_last: got %b want 0", evict_last); end
        n_checks++; if (evict_data !== 8'h00) begin n_errors++; $display("FAIL reset_evict_data: got %h want 00", evict_data); end
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_write_read();
        logic [7:0] exp;
        idle_inputs();
        way = 1'b0; index = 6'd5; offset = 3'd3; wdata = 8'h3C; wr_en = 1'b1;
        model[0][5][3] = 8'h3C;
        step();
        n_checks++; if (rvalid !== 1'b0) begin n_errors++; $display("FAIL wr0_rvalid: got %b want 0", rvalid); end
        way = 1'b1; wdata = 8'hA5;
        model[1][5][3] = 8'hA5;
        step();
        n_checks++; if (rvalid !== 1'b0) begin n_errors++; $display("FAIL wr1_rvalid: got %b want 0", rvalid); end
        for (int w = 1; w >= 0; w--) begin
            wr_en = 1'b0; rd_en = 1'b1; way = w[0:0];
            rd_q.push_back(model[w][5][3]);
            step();
            exp = rd_q.pop_front();
            n_checks++;
            if (rvalid !== 1'b1 || rdata !== exp) begin
                n_errors++; $display("FAIL rd_way%0d: got rvalid=%b rdata=%h want rvalid=1 rdata=%h", w, rvalid, rdata, exp);
            end
        end
        rd_en = 1'b0;
        step();
        n_checks++;
        if (rvalid !== 1'b0 || rdata !== 8'h3C) begin
            n_errors++; $display("FAIL rdata_hold: got rvalid=%b rdata=%h want rvalid=0 rdata=3c", rvalid, rdata);
        end
    endtask

    task automatic test_fill();
        int         beat;
        logic       want_done;
        logic [7:0] exp;
        idle_inputs();
        way = 1'b0; index = 6'd9; fill_start = 1'b1;
        step();
        fill_start = 1'b0;
        n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL fill_busy: got %b want 1", busy); end
        beat = 0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            fill_valid = !(cyc == 3 || cyc == 6);
            fill_data  = 8'(8'h10 + beat);
            if (fill_valid) model[0][9][beat] = fill_data;
            step();
            if (fill_valid) beat++;
            want_done = fill_valid && (beat == 8);
            n_checks++;
            if (fill_done !== want_done || busy !== !want_done) begin
                n_errors++; $display("FAIL fill_cyc%0d: got fill_done=%b busy=%b want fill_done=%b busy=%b",
                                     cyc, fill_done, busy, want_done, !want_done);
            end
        end
        fill_valid = 1'b0;
        step();
        n_checks++;
        if (fill_done !== 1'b0 || busy !== 1'b0) begin
            n_errors++; $display("FAIL fill_after: got fill_done=%b busy=%b want 0 0", fill_done, busy);
        end
        for (int o = 0; o < WORDS; o++) begin
            rd_en = 1'b1; offset = o[2:0];
            rd_q.push_back(model[0][9][o]);
            step();
            exp = rd_q.pop_front();
            n_checks++;
            if (rvalid !== 1'b1 || rdata !== exp) begin
                n_errors++; $display("FAIL fill_rd%0d: got rvalid=%b rdata=%h want rvalid=1 rdata=%h", o, rvalid, rdata, exp);
            end
        end
        rd_en = 1'b0;
    endtask

    task automatic test_evict();
        int         n;
        ev_t        e;
        logic [7:0] exp;
        idle_inputs();
        ev_q.delete();
        way = 1'b0; index = 6'd9; evict_start = 1'b1;
        for (int k = 0; k < WORDS; k++) ev_q.push_back('{data: model[0][9][k], last: (k == WORDS - 1)});
        step();
        evict_start = 1'b0;
        n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL evict_busy: got %b want 1", busy); end
        n = 0;
        while (evict_valid !== 1'b1 && n < 4) begin step(); n++; end
        n_checks++; if (evict_valid !== 1'b1) begin n_errors++; $display("FAIL evict_start_timeout: got evict_valid=%b want 1", evict_valid); end
        for (int k = 0; k < WORDS; k++) begin
            e = ev_q.pop_front();
            n_checks++;
            if (evict_valid !== 1'b1 || evict_data !== e.data || evict_last !== e.last) begin
                n_errors++; $display("FAIL evict_beat%0d: got v=%b d=%h l=%b want v=1 d=%h l=%b",
                                     k, evict_valid, evict_data, evict_last, e.data, e.last);
            end
            if (k == WORDS - 1) begin
                rd_en = 1'b1; offset = 3'd0;
                rd_q.push_back(model[0][9][0]);
            end
            step();
        end
        rd_en = 1'b0;
        exp = rd_q.pop_front();
        n_checks++;
        if (evict_valid !== 1'b0 || evict_last !== 1'b0 || evict_data !== 8'h00 || busy !== 1'b0) begin
            n_errors++; $display("FAIL evict_end: got v=%b l=%b d=%h busy=%b want 0 0 00 0", evict_valid, evict_last, evict_data, busy);
        end
        n_checks++;
        if (rvalid !== 1'b1 || rdata !== exp) begin
            n_errors++; $display("FAIL rd_after_evict: got rvalid=%b rdata=%h want rvalid=1 rdata=%h", rvalid, rdata, exp);
        end
    endtask

    task automatic test_conflict();
        int         n;
        ev_t        e;
        logic [7:0] exp;
        idle_inputs();
        ev_q.delete();
        way = 1'b0; index = 6'd9; offset = 3'd2;
        fill_start = 1'b1; evict_start = 1'b1; fill_valid = 1'b1; fill_data = 8'hEE;
        for (int k = 0; k < WORDS; k++) ev_q.push_back('{data: model[0][9][k], last: (k == WORDS - 1)});
        step();
        fill_start = 1'b0; evict_start = 1'b0; rd_en = 1'b1;
        n = 0;
        while (evict_valid !== 1'b1 && n < 4) begin
            n_checks++; if (rvalid !== 1'b0) begin n_errors++; $display("FAIL busy_rvalid_wait: got %b want 0", rvalid); end
            step(); n++;
        end
        for (int k = 0; k < WORDS; k++) begin
            e = ev_q.pop_front();
            n_checks++;
            if (evict_valid !== 1'b1 || evict_data !== e.data || evict_last !== e.last || rvalid !== 1'b0) begin
                n_errors++; $display("FAIL conflict_beat%0d: got v=%b d=%h l=%b rvalid=%b want v=1 d=%h l=%b rvalid=0",
                                     k, evict_valid, evict_data, evict_last, rvalid, e.data, e.last);
            end
            if (k == WORDS - 1) begin
                fill_valid = 1'b0; offset = 3'd1;
                rd_q.push_back(model[0][9][1]);
            end
            step();
        end
        rd_en = 1'b0;
        exp = rd_q.pop_front();
        n_checks++;
        if (rvalid !== 1'b1 || rdata !== exp || busy !== 1'b0) begin
            n_errors++; $display("FAIL conflict_rd: got rvalid=%b rdata=%h busy=%b want 1 %h 0", rvalid, rdata, busy, exp);
        end
    endtask

    task automatic test_rd_wr_same();
        logic [7:0] exp;
        idle_inputs();
        way = 1'b1; index = 6'd5; offset = 3'd3; wdata = 8'h5A; rd_en = 1'b1; wr_en = 1'b1;
        model[1][5][3] = 8'h5A;
        step();
        n_checks++; if (rvalid !== 1'b0) begin n_errors++; $display("FAIL rdwr_rvalid: got %b want 0", rvalid); end
        wr_en = 1'b0;
        rd_q.push_back(model[1][5][3]);
        step();
        rd_en = 1'b0;
        exp = rd_q.pop_front();
        n_checks++;
        if (rvalid !== 1'b1 || rdata !== exp) begin
            n_errors++; $display("FAIL rdwr_readback: got rvalid=%b rdata=%h want rvalid=1 rdata=%h", rvalid, rdata, exp);
        end
    endtask

    task automatic test_reset_mid_fill();
        logic [7:0] exp;
        idle_inputs();
        way = 1'b1; index = 6'd20; fill_start = 1'b1;
        step();
        fill_start = 1'b0; fill_valid = 1'b1;
        for (int b = 0; b < 4; b++) begin
            fill_data = 8'(8'h40 + b);
            model[1][20][b] = fill_data;
            step();
        end
        fill_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (busy !== 1'b0 || rdata !== 8'h00 || rvalid !== 1'b0 || fill_done !== 1'b0 ||
            evict_valid !== 1'b0 || evict_last !== 1'b0 || evict_data !== 8'h00) begin
            n_errors++; $display("FAIL async_reset: got busy=%b rdata=%h rvalid=%b fd=%b ev=%b el=%b ed=%h want all 0",
                                 busy, rdata, rvalid, fill_done, evict_valid, evict_last, evict_data);
        end
        step();
        rst_n = 1'b1;
        for (int c = 0; c < 2; c++) begin
            step();
            n_checks++;
            if (fill_done !== 1'b0 || busy !== 1'b0) begin
                n_errors++; $display("FAIL post_reset%0d: got fill_done=%b busy=%b want 0 0", c, fill_done, busy);
            end
        end
        for (int o = 0; o < 4; o++) begin
            rd_en = 1'b1; offset = o[2:0];
            rd_q.push_back(model[1][20][o]);
            step();
            exp = rd_q.pop_front();
            n_checks++;
            if (rvalid !== 1'b1 || rdata !== exp) begin
                n_errors++; $display("FAIL retained_rd%0d: got rvalid=%b rdata=%h want rvalid=1 rdata=%h", o, rvalid, rdata, exp);
            end
        end
        rd_en = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_write_read();
        test_fill();
        test_evict();
        test_conflict();
        test_rd_wr_same();
        test_reset_mid_fill();
        idle_inputs();
        step();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
